// File: rtl/rele_pkg.sv
// Constants and helpers shared by the relay status reader and the relay driver.
// Also holds the read-strobe decode that gives the low-byte read priority.
package rele_pkg;

  localparam int RELE_CH          = 12;
  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam int CNT_W            = 16;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_LOW  = 2'd1,
    RD_HIGH = 2'd2
  } rd_sel_t;

  // When both strobes rise together, the high-byte edge is dropped.
  function automatic rd_sel_t decode_rd(input logic [1:0] rise);
    if (rise[0])      return RD_LOW;
    else if (rise[1]) return RD_HIGH;
    else              return RD_NONE;
  endfunction

endpackage

// File: rtl/rele_debounce.sv
// One relay feedback channel: two-flop synchroniser followed by a counter debouncer.
// The toggle output pulses on the cycle before deb flips.
module rele_debounce
  import rele_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic fb,
  output logic deb,
  output logic toggle
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] count;

  assign toggle = (sync != deb) && (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      deb   <= 1'b0;
      count <= '0;
    end else begin
      meta <= fb;
      sync <= meta;
      if (sync == deb) begin
        count <= '0;
      end else if (toggle) begin
        deb   <= ~deb;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rele_status.sv
// Relay contact feedback reader: debounced state plus sticky change flags,
// read as two bytes with the high nibble snapshotted at the low-byte read.
module rele_status
  import rele_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [RELE_CH-1:0] fb,
  input  logic [1:0]        rd,
  output logic [7:0]        data,
  output logic              irq
);

  logic [RELE_CH-1:0] deb;
  logic [RELE_CH-1:0] toggle;
  logic [RELE_CH-1:0] chg;
  logic [RELE_CH-1:0] chg_next;
  logic [RELE_CH-1:0] clr;
  logic [3:0]         shadow;
  logic [1:0]         rd_d;
  logic [1:0]         rise;
  rd_sel_t            sel;

  generate
    for (genvar gi = 0; gi < RELE_CH; gi++) begin : g_ch
      rele_debounce #(
        .DEBOUNCE(DEBOUNCE)
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .fb     (fb[gi]),
        .deb    (deb[gi]),
        .toggle (toggle[gi])
      );
    end
  endgenerate

  assign rise = rd & ~rd_d;
  assign sel  = decode_rd(rise);

  // A toggle arriving in the same cycle as a clear is kept.
  always_comb begin
    clr = '0;
    case (sel)
      RD_LOW:  clr[7:0]  = '1;
      RD_HIGH: clr[11:8] = '1;
      default: clr       = '0;
    endcase
    chg_next = (chg & ~clr) | toggle;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_d   <= '0;
      chg    <= '0;
      shadow <= '0;
      data   <= '0;
      irq    <= 1'b0;
    end else begin
      rd_d <= rd;
      chg  <= chg_next;
      irq  <= |chg_next;
      case (sel)
        RD_LOW: begin
          data   <= deb[7:0];
          shadow <= deb[11:8];
        end
        RD_HIGH: data <= {chg[11:8], shadow};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rele_status.sv
// Directed and randomized checks of rele_status against a window-based behavioural model.
module tb_rele_status;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] fb = '0;
  logic [1:0]  rd = '0;
  logic [7:0]  data;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Model: fb reaches the debouncer two edges late; deb flips once the last D
  // synchronised samples all disagree with it.
  logic [11:0] fq[$];
  logic [11:0] sh[$];
  logic [11:0] mdeb, mchg;
  logic [3:0]  mshadow;
  logic [7:0]  mdata;
  logic [1:0]  mprev;

  always #5 clk = ~clk;

  rele_status #(.DEBOUNCE(D)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .fb     (fb),
    .rd     (rd),
    .data   (data),
    .irq    (irq)
  );

  function void mclear();
    fq.delete();
    fq.push_back(12'h0);
    fq.push_back(12'h0);
    sh.delete();
    mdeb = '0; mchg = '0; mshadow = '0; mdata = '0; mprev = '0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [11:0] sync, tog, clr;
    logic [1:0]  rise;
    @(posedge clk);
    if (!reset_n) begin
      mclear();
    end else begin
      fq.push_back(fb);
      sync = fq.pop_front();
      sh.push_back(sync);
      if (sh.size() > D) void'(sh.pop_front());
      tog = '0;
      if (sh.size() == D) begin
        for (int i = 0; i < 12; i++) begin
          bit all;
          all = 1'b1;
          foreach (sh[k]) if (sh[k][i] == mdeb[i]) all = 1'b0;
          tog[i] = all;
        end
      end
      rise  = rd & ~mprev;
      mprev = rd;
      clr   = '0;
      if (rise[0]) begin
        mdata   = mdeb[7:0];
        mshadow = mdeb[11:8];
        clr     = 12'h0FF;
      end else if (rise[1]) begin
        mdata = {mchg[11:8], mshadow};
        clr   = 12'hF00;
      end
      mchg = (mchg & ~clr) | tog;
      mdeb = mdeb ^ tog;
    end
    @(negedge clk);
    chk("model_data", data, mdata);
    chk("model_irq", {7'b0, irq}, {7'b0, |mchg});
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [1:0] v);
    rd = v;
    tick();
    rd = 2'b00;
    tick();
  endtask

  task automatic do_reset();
    rd = 2'b00;
    reset_n = 1'b0;
    mclear();
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset with all contacts closed: deb appears after 2+D edges.
    fb = 12'hFFF;
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("boot_irq_low", {7'b0, irq}, 8'h00);
      chk("boot_data_low", data, 8'h00);
    end
    tick();
    chk("boot_irq_high", {7'b0, irq}, 8'h01);
    pulse(2'b01);
    chk("boot_low_byte", data, 8'hFF);
    pulse(2'b10);
    chk("boot_high_byte", data, 8'hFF);
    chk("boot_irq_cleared", {7'b0, irq}, 8'h00);

    // Glitch shorter than D must not reach deb.
    fb = 12'h000;
    wait_n(10);
    pulse(2'b01);
    pulse(2'b10);
    chk("open_high_byte", data, 8'hF0);
    fb = 12'h008;
    wait_n(3);
    fb = 12'h000;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("glitch_irq", {7'b0, irq}, 8'h00);
    end
    pulse(2'b01);
    chk("glitch_low_byte", data, 8'h00);

    // Coherent read: high byte shows the nibble captured at the low read.
    fb = 12'hA5C;
    wait_n(10);
    pulse(2'b01);
    chk("coherent_low", data, 8'h5C);
    fb = 12'h35C;
    wait_n(10);
    pulse(2'b10);
    chk("coherent_high", data, 8'hBA);

    // Fresh read pair after things settle clears every flag.
    pulse(2'b01);
    chk("clear_low", data, 8'h5C);
    pulse(2'b10);
    chk("clear_high", data, 8'h03);
    chk("clear_irq", {7'b0, irq}, 8'h00);

    // Simultaneous strobes: only the low byte, high flags survive.
    fb = 12'hC5C;
    wait_n(10);
    rd = 2'b11;
    tick();
    rd = 2'b00;
    tick();
    chk("collision_low", data, 8'h5C);
    pulse(2'b10);
    chk("collision_high", data, 8'hFC);
    chk("collision_irq", {7'b0, irq}, 8'h00);

    // deb[0] toggles on the same edge as a low-byte read.
    fb = 12'hC5D;
    wait_n(5);
    rd = 2'b01;
    tick();
    chk("race_data", data, 8'h5C);
    chk("race_irq", {7'b0, irq}, 8'h01);
    rd = 2'b00;
    tick();
    pulse(2'b01);
    chk("race_reread", data, 8'h5D);
    chk("race_irq_clr", {7'b0, irq}, 8'h00);

    // Reset in the middle of a debounce restarts the full latency.
    fb = 12'h000;
    wait_n(10);
    pulse(2'b01);
    pulse(2'b10);
    fb = 12'hFFF;
    wait_n(3);
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("midrst_irq_low", {7'b0, irq}, 8'h00);
    end
    tick();
    chk("midrst_irq_high", {7'b0, irq}, 8'h01);

    // Random contact activity and read strobes against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) fb = fb ^ 12'($urandom);
      repeat ($urandom_range(1, 7)) begin
        rd = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        tick();
      end
    end
    rd = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
